// File: rtl/equiv_sweeper.sv
// Exhaustive equivalence sweeper: steps a vector through every input combination,
// lets both implementations settle, and counts vectors where they disagree.
// Optional first-mismatch capture on fail_vec when EQUIV_SWEEPER_FAIL_LOG_EN is defined.
module equiv_sweeper #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_ref,
  input  logic            y_dut,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [N_IN:0]   mismatch_cnt
`ifdef EQUIV_SWEEPER_FAIL_LOG_EN
  ,
  output logic [N_IN-1:0] fail_vec
`endif
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // registered in DONE; busy covers exactly the SETTLE and SAMPLE states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN+1)'(1);

  state_t        state;
  logic [3:0]    settle_cnt;
  logic          miss;
  logic [N_IN:0] cnt_next;

  assign miss     = y_ref ^ y_dut;
  assign cnt_next = miss ? (mismatch_cnt + CNT_ONE) : mismatch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vec_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_cnt <= '0;
      settle_cnt   <= '0;
`ifdef EQUIV_SWEEPER_FAIL_LOG_EN
      fail_vec     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SETTLE;
            vec_out      <= '0;
            mismatch_cnt <= '0;
            equal        <= 1'b0;
            busy         <= 1'b1;
            settle_cnt   <= SETTLE_LOAD;
`ifdef EQUIV_SWEEPER_FAIL_LOG_EN
            fail_vec     <= '0;
`endif
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          mismatch_cnt <= cnt_next;
`ifdef EQUIV_SWEEPER_FAIL_LOG_EN
          // Only the first disagreement of the sweep is logged.
          if (miss && (mismatch_cnt == '0)) fail_vec <= vec_out;
`endif
          if (vec_out == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            equal <= (cnt_next == '0);
          end else begin
            state      <= SETTLE;
            vec_out    <= vec_out + VEC_ONE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
